dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_pkg.sv | 34 +++
 rtl/dmem_array.sv | 27 ++
 rtl/dmem_responder.sv | 162 ++++++++++++++++
 tb/tb_dmem_responder.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder:
// FSM state encoding, default base address and access error codes.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_RANGE    = 2'd2;

  // off is addr - base (modular); limit is the window size in bytes.
  function automatic logic [1:0] access_err(
    input logic [31:0] addr,
    input logic [31:0] off,
    input logic [31:0] base,
    input logic [31:0] limit
  );
    logic [1:0] code;
    code = ERR_NONE;
    if (addr[1:0] != 2'b00) begin
      code = ERR_MISALIGN;
    end else if (addr < base || off >= limit) begin
      code = ERR_RANGE;
    end
    return code;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous byte-enabled write, combinational read.
// Ports: clk, we, addr (word index), wdata, be, rdata. No reset.
module dmem_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    be,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) begin
        mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder with valid/ready request and
// response channels. Ports: clk, rst (async, active-low), req_*
// (valid/ready/we/addr/wdata/be), rsp_* (valid/ready/rdata/err).
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] LIMIT =
    32'(DEPTH_WORDS) << 2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam bit NO_WAIT = (WAIT_CYCLES == 0);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic          c_we;
  logic [31:0]   c_addr;
  logic [31:0]   c_wdata;
  logic [3:0]    c_be;
  logic [31:0]   c_off;
  logic [1:0]    c_err;
  logic          bad;
  logic          commit;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;

  // With no wait states the access commits on the accepting
  // edge, so the operands come straight from the request port.
  always_comb begin
    c_we    = we_q;
    c_addr  = addr_q;
    c_wdata = wdata_q;
    c_be    = be_q;
    commit  = 1'b0;
    if (state_q == ST_IDLE) begin
      c_we    = req_we;
      c_addr  = req_addr;
      c_wdata = req_wdata;
      c_be    = req_be;
      commit  = req_valid && NO_WAIT;
    end else if (state_q == ST_WAIT) begin
      commit  = (cnt_q <= 4'd1);
    end
    c_off    = c_addr - BASE_ADDR;
    c_err    = access_err(c_addr, c_off, BASE_ADDR, LIMIT);
    bad      = (c_err != ERR_NONE);
    mem_addr = c_off[AW+1:2];
    mem_we   = commit && c_we && !bad;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (NO_WAIT) begin
            state_d = ST_RESP;
          end else begin
            cnt_d   = WAIT_INIT;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Read data is sampled before the write lands: old contents.
    if (commit) begin
      err_d   = bad;
      rdata_d = (c_we || bad) ? 32'h0 : mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (c_wdata),
    .be    (c_be),
    .rdata (mem_rdata)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a 2-wait-state instance and a
// zero-wait instance, checked through an expected-response queue.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_be = 4'h0;

  logic        req_valid0 = 1'b0;
  logic        rsp_ready0 = 1'b0;
  logic        req_ready0, rsp_valid0, rsp_err0;
  logic [31:0] rsp_rdata0;

  logic        req_valid1 = 1'b0;
  logic        rsp_ready1 = 1'b0;
  logic        req_ready1, rsp_valid1, rsp_err1;
  logic [31:0] rsp_rdata1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] xr;
    logic        xe;
  } vec_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  dmem_responder #(
    .WAIT_CYCLES (2)
  ) dut0 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid0),
    .req_ready (req_ready0),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid0),
    .rsp_ready (rsp_ready0),
    .rsp_rdata (rsp_rdata0),
    .rsp_err   (rsp_err0)
  );

  dmem_responder #(
    .WAIT_CYCLES (0)
  ) dut1 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid1),
    .req_ready (req_ready1),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid1),
    .rsp_ready (rsp_ready1),
    .rsp_rdata (rsp_rdata1),
    .rsp_err   (rsp_err1)
  );

  // Drives one transaction and reports what the DUT returned.
  // Starts just after a rising edge, returns 1 after the
  // response handshake edge.
  task automatic send(
    input  bit          sel,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    input  int          hold,
    output logic [31:0] rd,
    output logic        er,
    output int          lat,
    output int          stalls,
    output bit          acc_rv,
    output bit          stable,
    output bit          tmo
  );
    tmo = 1'b0;
    stable = 1'b1;
    stalls = 0;
    lat = 0;
    acc_rv = 1'b0;
    rd = 32'h0;
    er = 1'b0;
    req_we = we;
    req_addr = addr;
    req_wdata = wdata;
    req_be = be;
    if (sel) req_valid1 = 1'b1;
    else     req_valid0 = 1'b1;
    @(negedge clk);
    while ((sel ? req_ready1 : req_ready0) !== 1'b1
           && !tmo) begin
      stalls++;
      if (stalls > 50) tmo = 1'b1;
      else @(negedge clk);
    end
    acc_rv = sel ? rsp_valid1 : rsp_valid0;
    @(posedge clk);
    #1;
    req_valid0 = 1'b0;
    req_valid1 = 1'b0;
    if (tmo) return;
    do begin
      @(negedge clk);
      lat++;
    end while ((sel ? rsp_valid1 : rsp_valid0) !== 1'b1
               && lat < 50);
    if ((sel ? rsp_valid1 : rsp_valid0) !== 1'b1) begin
      tmo = 1'b1;
      return;
    end
    rd = sel ? rsp_rdata1 : rsp_rdata0;
    er = sel ? rsp_err1 : rsp_err0;
    if ((sel ? req_ready1 : req_ready0) !== 1'b0)
      stable = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      if ((sel ? rsp_valid1 : rsp_valid0) !== 1'b1 ||
          (sel ? rsp_rdata1 : rsp_rdata0) !== rd ||
          (sel ? rsp_err1 : rsp_err0) !== er ||
          (sel ? req_ready1 : req_ready0) !== 1'b0)
        stable = 1'b0;
    end
    if (sel) rsp_ready1 = 1'b1;
    else     rsp_ready0 = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready0 = 1'b0;
    rsp_ready1 = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (req_ready0 !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_req_ready: got %b want 1",
               req_ready0);
    end
    vectors++;
    if (rsp_valid0 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_rsp_valid: got %b want 0",
               rsp_valid0);
    end
    vectors++;
    if (rsp_rdata0 !== 32'h0 || rsp_err0 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_rsp_data: got %h/%b want 0/0",
               rsp_rdata0, rsp_err0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_read();
    vec_t v[4];
    exp_t e;
    logic [31:0] rd;
    logic er;
    int lat, stalls;
    bit acc_rv, stable, tmo;
    v[0] = '{1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 4'hF,
             32'h0, 1'b0};
    v[1] = '{1'b0, 32'h1001_0004, 32'h0, 4'h0,
             32'hDEAD_BEEF, 1'b0};
    v[2] = '{1'b1, 32'h1001_0FFC, 32'h5AA5_C33C, 4'hF,
             32'h0, 1'b0};
    v[3] = '{1'b0, 32'h1001_0FFC, 32'h0, 4'hF,
             32'h5AA5_C33C, 1'b0};
    foreach (v[i]) begin
      sb.push_back('{rdata: v[i].xr, err: v[i].xe, lat: 3});
      send(1'b0, v[i].we, v[i].addr, v[i].wdata, v[i].be, 0,
           rd, er, lat, stalls, acc_rv, stable, tmo);
      e = sb.pop_front();
      vectors++;
      if (tmo || rd !== e.rdata || er !== e.err) begin
        miscompares++;
        $display("FAIL wr_rd[%0d]: got %h/%b tmo=%b want %h/%b",
                 i, rd, er, tmo, e.rdata, e.err);
      end
      vectors++;
      if (lat != e.lat) begin
        miscompares++;
        $display("FAIL wr_rd_lat[%0d]: got %0d want %0d",
                 i, lat, e.lat);
      end
    end
  endtask

  task automatic test_byte_enable();
    vec_t v[6];
    exp_t e;
    logic [31:0] rd;
    logic er;
    int lat, stalls;
    bit acc_rv, stable, tmo;
    v[0] = '{1'b1, 32'h1001_0004, 32'h0000_00AA, 4'b0001,
             32'h0, 1'b0};
    v[1] = '{1'b0, 32'h1001_0004, 32'h0, 4'h0,
             32'hDEAD_BEAA, 1'b0};
    v[2] = '{1'b1, 32'h1001_0004, 32'hFFFF_FFFF, 4'b0000,
             32'h0, 1'b0};
    v[3] = '{1'b0, 32'h1001_0004, 32'h0, 4'h1,
             32'hDEAD_BEAA, 1'b0};
    v[4] = '{1'b1, 32'h1001_0004, 32'h1234_0000, 4'b1100,
             32'h0, 1'b0};
    v[5] = '{1'b0, 32'h1001_0004, 32'h0, 4'h0,
             32'h1234_BEAA, 1'b0};
    foreach (v[i]) begin
      sb.push_back('{rdata: v[i].xr, err: v[i].xe, lat: 3});
      send(1'b0, v[i].we, v[i].addr, v[i].wdata, v[i].be, 0,
           rd, er, lat, stalls, acc_rv, stable, tmo);
      e = sb.pop_front();
      vectors++;
      if (tmo || rd !== e.rdata || er !== e.err) begin
        miscompares++;
        $display("FAIL be[%0d]: got %h/%b tmo=%b want %h/%b",
                 i, rd, er, tmo, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_errors();
    vec_t v[7];
    exp_t e;
    logic [31:0] rd;
    logic er;
    int lat, stalls;
    bit acc_rv, stable, tmo;
    v[0] = '{1'b1, 32'h1001_0000, 32'h0123_4567, 4'hF,
             32'h0, 1'b0};
    v[1] = '{1'b0, 32'h1001_0002, 32'h0, 4'hF,
             32'h0, 1'b1};
    v[2] = '{1'b0, 32'h1000_FFFC, 32'h0, 4'hF,
             32'h0, 1'b1};
    v[3] = '{1'b0, 32'h1001_1000, 32'h0, 4'hF,
             32'h0, 1'b1};
    v[4] = '{1'b1, 32'h1001_0002, 32'hFFFF_FFFF, 4'hF,
             32'h0, 1'b1};
    v[5] = '{1'b1, 32'h1001_1000, 32'hFFFF_FFFF, 4'hF,
             32'h0, 1'b1};
    v[6] = '{1'b0, 32'h1001_0000, 32'h0, 4'h0,
             32'h0123_4567, 1'b0};
    foreach (v[i]) begin
      sb.push_back('{rdata: v[i].xr, err: v[i].xe, lat: 3});
      send(1'b0, v[i].we, v[i].addr, v[i].wdata, v[i].be, 0,
           rd, er, lat, stalls, acc_rv, stable, tmo);
      e = sb.pop_front();
      vectors++;
      if (tmo || rd !== e.rdata || er !== e.err) begin
        miscompares++;
        $display("FAIL err[%0d]: got %h/%b tmo=%b want %h/%b",
                 i, rd, er, tmo, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_hold();
    exp_t e;
    logic [31:0] rd;
    logic er;
    int lat, stalls;
    bit acc_rv, stable, tmo;
    sb.push_back('{rdata: 32'h1234_BEAA, err: 1'b0, lat: 3});
    send(1'b0, 1'b0, 32'h1001_0004, 32'h0, 4'hF, 5,
         rd, er, lat, stalls, acc_rv, stable, tmo);
    e = sb.pop_front();
    vectors++;
    if (tmo || rd !== e.rdata || er !== e.err) begin
      miscompares++;
      $display("FAIL hold_data: got %h/%b tmo=%b want %h/%b",
               rd, er, tmo, e.rdata, e.err);
    end
    vectors++;
    if (stable !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_stable: got %b want 1", stable);
    end
    @(negedge clk);
    vectors++;
    if (req_ready0 !== 1'b1 || rsp_valid0 !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_release: ready/valid %b/%b want 1/0",
               req_ready0, rsp_valid0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_in_wait();
    exp_t e;
    logic [31:0] rd;
    logic er;
    int lat, stalls;
    bit acc_rv, stable, tmo;
    send(1'b0, 1'b1, 32'h1001_0008, 32'hCAFE_F00D, 4'hF, 0,
         rd, er, lat, stalls, acc_rv, stable, tmo);
    sb.push_back('{rdata: 32'hCAFE_F00D, err: 1'b0, lat: 3});
    send(1'b0, 1'b0, 32'h1001_0008, 32'h0, 4'hF, 0,
         rd, er, lat, stalls, acc_rv, stable, tmo);
    e = sb.pop_front();
    vectors++;
    if (tmo || rd !== e.rdata) begin
      miscompares++;
      $display("FAIL rw_pre: got %h tmo=%b want %h",
               rd, tmo, e.rdata);
    end
    req_we = 1'b1;
    req_addr = 32'h1001_0008;
    req_wdata = 32'h1234_5678;
    req_be = 4'hF;
    req_valid0 = 1'b1;
    @(posedge clk);
    #1 req_valid0 = 1'b0;
    @(negedge clk);
    vectors++;
    if (req_ready0 !== 1'b0) begin
      miscompares++;
      $display("FAIL rw_in_wait: req_ready got %b want 0",
               req_ready0);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (req_ready0 !== 1'b1 || rsp_valid0 !== 1'b0 ||
        rsp_rdata0 !== 32'h0 || rsp_err0 !== 1'b0) begin
      miscompares++;
      $display("FAIL rw_clear: got %b/%b/%h/%b want 1/0/0/0",
               req_ready0, rsp_valid0, rsp_rdata0, rsp_err0);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{rdata: 32'hCAFE_F00D, err: 1'b0, lat: 3});
    send(1'b0, 1'b0, 32'h1001_0008, 32'h0, 4'hF, 0,
         rd, er, lat, stalls, acc_rv, stable, tmo);
    e = sb.pop_front();
    vectors++;
    if (tmo || rd !== e.rdata || er !== e.err) begin
      miscompares++;
      $display("FAIL rw_post: got %h/%b tmo=%b want %h/%b",
               rd, er, tmo, e.rdata, e.err);
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[5];
    exp_t e;
    logic [31:0] rd;
    logic er;
    int lat, stalls;
    bit acc_rv, stable, tmo;
    v[0] = '{1'b1, 32'h1001_0000, 32'h1111_1111, 4'hF,
             32'h0, 1'b0};
    v[1] = '{1'b1, 32'h1001_0004, 32'h2222_2222, 4'hF,
             32'h0, 1'b0};
    v[2] = '{1'b0, 32'h1001_0000, 32'h0, 4'h0,
             32'h1111_1111, 1'b0};
    v[3] = '{1'b0, 32'h1001_0004, 32'h0, 4'h0,
             32'h2222_2222, 1'b0};
    v[4] = '{1'b0, 32'h1001_0000, 32'h0, 4'h0,
             32'h1111_1111, 1'b0};
    foreach (v[i]) begin
      sb.push_back('{rdata: v[i].xr, err: v[i].xe, lat: 1});
      send(1'b1, v[i].we, v[i].addr, v[i].wdata, v[i].be, 0,
           rd, er, lat, stalls, acc_rv, stable, tmo);
      e = sb.pop_front();
      vectors++;
      if (tmo || rd !== e.rdata || er !== e.err) begin
        miscompares++;
        $display("FAIL b2b[%0d]: got %h/%b tmo=%b want %h/%b",
                 i, rd, er, tmo, e.rdata, e.err);
      end
      vectors++;
      if (lat != e.lat) begin
        miscompares++;
        $display("FAIL b2b_lat[%0d]: got %0d want %0d",
                 i, lat, e.lat);
      end
      vectors++;
      if (stalls != 0 || acc_rv !== 1'b0 || stable !== 1'b1)
      begin
        miscompares++;
        $display("FAIL b2b_idle[%0d]: stalls=%0d rv=%b st=%b",
                 i, stalls, acc_rv, stable);
        $display("  want stalls=0 rv=0 st=1");
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_errors();
    test_hold();
    test_reset_in_wait();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
